// File: rtl/rx_detection_scheduler.sv
// rtl/rx_detection_scheduler.sv - arms the peak detector, bounds each listen, qualifies and holds results
// States: IDLE -> LISTEN -> (HOLD ->) GUARD -> LISTEN/IDLE; one shared timer serves LISTEN and GUARD.
`timescale 1ns/1ps
module rx_detection_scheduler #(
  parameter logic [31:0]        TIMEOUT_CYCLES = 32'd5000000,
  parameter logic [15:0]        GUARD_CYCLES   = 16'd16,
  parameter logic signed [40:0] MIN_PEAK       = 41'sd1000
) (
  input  logic        crx_clk,
  input  logic        rrx_rst,
  input  logic        erx_en,
  input  logic        iarm_start,
  input  logic        iabort,
  input  logic        icontinuous,
  input  logic        ipeak_trigger,
  input  logic [40:0] ipeak_value,
  input  logic [3:0]  ipeak_seq,
  input  logic [15:0] ipeak_time,
  input  logic        iresult_ack,
  output logic        o_det_en,
  output logic        o_result_valid,
  output logic [40:0] o_result_value,
  output logic [3:0]  o_result_seq,
  output logic [15:0] o_result_time,
  output logic        o_timeout,
  output logic        o_busy,
  output logic [7:0]  o_det_count,
  output logic [7:0]  o_reject_count
);

  typedef enum logic [1:0] {S_IDLE, S_LISTEN, S_HOLD, S_GUARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        valid_q, valid_d;
  logic [40:0] value_q, value_d;
  logic [3:0]  seq_q, seq_d;
  logic [15:0] time_q, time_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  det_cnt_q, det_cnt_d;
  logic [7:0]  rej_cnt_q, rej_cnt_d;

  logic listen_last;
  logic guard_last;
  logic peak_ok;

  assign listen_last = (timer_q == (TIMEOUT_CYCLES - 32'd1));
  assign guard_last  = (timer_q == {16'd0, GUARD_CYCLES - 16'd1});
  assign peak_ok     = ($signed(ipeak_value) >= MIN_PEAK);

  always_ff @(posedge crx_clk) begin
    if (!rrx_rst) begin
      state_q   <= S_IDLE;
      timer_q   <= 32'd0;
      valid_q   <= 1'b0;
      value_q   <= 41'd0;
      seq_q     <= 4'd0;
      time_q    <= 16'd0;
      timeout_q <= 1'b0;
      det_cnt_q <= 8'd0;
      rej_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      valid_q   <= valid_d;
      value_q   <= value_d;
      seq_q     <= seq_d;
      time_q    <= time_d;
      timeout_q <= timeout_d;
      det_cnt_q <= det_cnt_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    valid_d   = valid_q;
    value_d   = value_q;
    seq_d     = seq_q;
    time_d    = time_q;
    timeout_d = 1'b0;
    det_cnt_d = det_cnt_q;
    rej_cnt_d = rej_cnt_q;

    // Block disable wipes everything; abort keeps counters and the last result.
    if (!erx_en) begin
      state_d   = S_IDLE;
      timer_d   = 32'd0;
      valid_d   = 1'b0;
      value_d   = 41'd0;
      seq_d     = 4'd0;
      time_d    = 16'd0;
      det_cnt_d = 8'd0;
      rej_cnt_d = 8'd0;
    end else if (iabort) begin
      state_d = S_IDLE;
      timer_d = 32'd0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = 32'd0;
          if (iarm_start) state_d = S_LISTEN;
        end
        S_LISTEN: begin
          timer_d = timer_q + 32'd1;
          if (ipeak_trigger) begin
            timer_d = 32'd0;
            if (peak_ok) begin
              value_d   = ipeak_value;
              seq_d     = ipeak_seq;
              time_d    = ipeak_time;
              valid_d   = 1'b1;
              det_cnt_d = (det_cnt_q == 8'hFF) ? det_cnt_q : det_cnt_q + 8'd1;
              state_d   = S_HOLD;
            end else begin
              rej_cnt_d = (rej_cnt_q == 8'hFF) ? rej_cnt_q : rej_cnt_q + 8'd1;
              state_d   = S_GUARD;
            end
          end else if (listen_last) begin
            timer_d   = 32'd0;
            timeout_d = 1'b1;
            state_d   = S_GUARD;
          end
        end
        S_HOLD: begin
          timer_d = 32'd0;
          if (iresult_ack) begin
            valid_d = 1'b0;
            state_d = S_GUARD;
          end
        end
        S_GUARD: begin
          timer_d = timer_q + 32'd1;
          if (guard_last) begin
            timer_d = 32'd0;
            state_d = icontinuous ? S_LISTEN : S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = 32'd0;
        end
      endcase
    end
  end

  assign o_det_en       = (state_q == S_LISTEN);
  assign o_busy         = (state_q != S_IDLE);
  assign o_result_valid = valid_q;
  assign o_result_value = value_q;
  assign o_result_seq   = seq_q;
  assign o_result_time  = time_q;
  assign o_timeout      = timeout_q;
  assign o_det_count    = det_cnt_q;
  assign o_reject_count = rej_cnt_q;

endmodule

// File: tb/tb_rx_detection_scheduler.sv
// tb/tb_rx_detection_scheduler.sv - scoreboard bench for rx_detection_scheduler
`timescale 1ns/1ps
module tb_rx_detection_scheduler;

  localparam int     T    = 100;
  localparam int     G    = 4;
  localparam longint MINP = 1000;

  logic        crx_clk = 1'b0;
  logic        rrx_rst, erx_en, iarm_start, iabort, icontinuous, ipeak_trigger, iresult_ack;
  logic [40:0] ipeak_value;
  logic [3:0]  ipeak_seq;
  logic [15:0] ipeak_time;
  logic        o_det_en, o_result_valid, o_timeout, o_busy;
  logic [40:0] o_result_value;
  logic [3:0]  o_result_seq;
  logic [15:0] o_result_time;
  logic [7:0]  o_det_count, o_reject_count;

  always #5 crx_clk = ~crx_clk;

  rx_detection_scheduler #(
    .TIMEOUT_CYCLES(32'd100),
    .GUARD_CYCLES  (16'd4),
    .MIN_PEAK      (41'sd1000)
  ) dut (
    .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en),
    .iarm_start(iarm_start), .iabort(iabort), .icontinuous(icontinuous),
    .ipeak_trigger(ipeak_trigger), .ipeak_value(ipeak_value),
    .ipeak_seq(ipeak_seq), .ipeak_time(ipeak_time), .iresult_ack(iresult_ack),
    .o_det_en(o_det_en), .o_result_valid(o_result_valid),
    .o_result_value(o_result_value), .o_result_seq(o_result_seq),
    .o_result_time(o_result_time), .o_timeout(o_timeout), .o_busy(o_busy),
    .o_det_count(o_det_count), .o_reject_count(o_reject_count)
  );

  typedef struct {
    bit     is_to;
    longint value;
    longint seq;
    longint tm;
    longint det;
  } ev_t;

  ev_t    sb[$];
  int     checks = 0;
  int     errors = 0;
  longint det_m = 0, rej_m = 0;
  longint last_v = 0, last_s = 0, last_t = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge crx_clk);
    #1;
  endtask

  // Monitor: every accepted result or timeout pulse must match the head of the scoreboard.
  task automatic take(input bit is_to);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected actual=event(timeout=%0d) required=none", is_to);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", longint'(is_to), longint'(e.is_to));
      if (!is_to && !e.is_to) begin
        chk("sb_value", longint'($signed(o_result_value)), e.value);
        chk("sb_seq", longint'(o_result_seq), e.seq);
        chk("sb_time", longint'(o_result_time), e.tm);
        chk("sb_det_count", longint'(o_det_count), e.det);
      end
    end
  endtask

  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge crx_clk);
      if (rrx_rst === 1'b1) begin
        if (o_timeout) take(1'b1);
        if (o_result_valid && !prev_valid) take(1'b0);
      end
      prev_valid = o_result_valid;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic arm();
    iarm_start = 1'b1;
    tick();
    iarm_start = 1'b0;
    chk("arm_det_en", longint'(o_det_en), 1);
    chk("arm_busy", longint'(o_busy), 1);
  endtask

  task automatic trigger(input longint v, input longint s, input longint t, output bit acc);
    ipeak_trigger = 1'b1;
    ipeak_value   = v[40:0];
    ipeak_seq     = s[3:0];
    ipeak_time    = t[15:0];
    acc = (v >= MINP);
    if (acc) begin
      det_m  = (det_m < 255) ? det_m + 1 : 255;
      last_v = v; last_s = s; last_t = t;
      sb.push_back('{is_to: 1'b0, value: v, seq: s, tm: t, det: det_m});
    end else begin
      rej_m = (rej_m < 255) ? rej_m + 1 : 255;
    end
    tick();
    ipeak_trigger = 1'b0;
  endtask

  task automatic guard_to_idle();
    repeat (G - 1) tick();
    chk("guard_busy", longint'(o_busy), 1);
    chk("guard_det_en", longint'(o_det_en), 0);
    tick();
    chk("idle_busy", longint'(o_busy), 0);
    chk("idle_det_en", longint'(o_det_en), 0);
  endtask

  task automatic episode(input int k, input longint v, input longint s, input longint t, input int ackd);
    bit acc;
    arm();
    repeat (k) tick();
    trigger(v, s, t, acc);
    chk("trig_det_en", longint'(o_det_en), 0);
    chk("trig_valid", longint'(o_result_valid), longint'(acc));
    chk("det_count", longint'(o_det_count), det_m);
    chk("reject_count", longint'(o_reject_count), rej_m);
    if (acc) begin
      repeat (ackd) tick();
      chk("hold_valid", longint'(o_result_valid), 1);
      chk("hold_busy", longint'(o_busy), 1);
      iresult_ack = 1'b1;
      tick();
      iresult_ack = 1'b0;
      chk("ack_valid", longint'(o_result_valid), 0);
    end
    guard_to_idle();
    chk("kept_value", longint'($signed(o_result_value)), last_v);
  endtask

  task automatic timeout_ep();
    int n;
    n = 0;
    arm();
    sb.push_back('{is_to: 1'b1, value: 0, seq: 0, tm: 0, det: det_m});
    while (o_det_en && n < T + 20) begin
      n++;
      tick();
    end
    chk("listen_len", longint'(n), longint'(T));
    chk("timeout_pulse", longint'(o_timeout), 1);
    tick();
    chk("timeout_one_cycle", longint'(o_timeout), 0);
    repeat (G - 2) tick();
    chk("to_guard_busy", longint'(o_busy), 1);
    tick();
    chk("to_idle_busy", longint'(o_busy), 0);
    chk("to_det_count", longint'(o_det_count), det_m);
  endtask

  initial begin
    bit     acc;
    int     n;
    longint v;
    rrx_rst = 1'b0; erx_en = 1'b0; iarm_start = 1'b0; iabort = 1'b0;
    icontinuous = 1'b0; ipeak_trigger = 1'b0; ipeak_value = '0;
    ipeak_seq = '0; ipeak_time = '0; iresult_ack = 1'b0;
    repeat (3) tick();
    chk("rst_det_en", longint'(o_det_en), 0);
    chk("rst_valid", longint'(o_result_valid), 0);
    chk("rst_value", longint'(o_result_value), 0);
    chk("rst_seq", longint'(o_result_seq), 0);
    chk("rst_time", longint'(o_result_time), 0);
    chk("rst_timeout", longint'(o_timeout), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_det_count", longint'(o_det_count), 0);
    chk("rst_reject_count", longint'(o_reject_count), 0);
    rrx_rst = 1'b1; erx_en = 1'b1;
    tick();

    episode(10, 5000, 7, 'h1234, 3);
    timeout_ep();
    episode(99, 2000, 3, 'h55, 0);
    episode(20, MINP - 1, 1, 1, 0);
    episode(5, MINP, 2, 2, 1);

    // Continuous reject: detector re-enabled after exactly G cycles low.
    icontinuous = 1'b1;
    arm();
    repeat (4) tick();
    trigger(500, 4, 4, acc);
    chk("cont_rej_valid", longint'(o_result_valid), 0);
    chk("cont_rej_count", longint'(o_reject_count), rej_m);
    n = 0;
    while (!o_det_en && n < 50) begin
      n++;
      tick();
    end
    chk("cont_guard_len", longint'(n), longint'(G));
    icontinuous = 1'b0;
    iabort = 1'b1;
    tick();
    iabort = 1'b0;
    chk("abort_listen_busy", longint'(o_busy), 0);

    // Abort during HOLD, with an ignored arm request first.
    arm();
    trigger(3000, 9, 'hBEEF, acc);
    iarm_start = 1'b1;
    tick();
    iarm_start = 1'b0;
    chk("hold_ignores_arm", longint'(o_result_valid), 1);
    chk("hold_det_en", longint'(o_det_en), 0);
    iabort = 1'b1;
    tick();
    iabort = 1'b0;
    chk("abort_hold_valid", longint'(o_result_valid), 0);
    chk("abort_hold_busy", longint'(o_busy), 0);
    chk("abort_hold_value", longint'($signed(o_result_value)), last_v);
    chk("abort_hold_seq", longint'(o_result_seq), last_s);
    chk("abort_hold_time", longint'(o_result_time), last_t);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        timeout_ep();
      end else begin
        case ($urandom_range(0, 3))
          0: v = MINP - 1;
          1: v = MINP;
          2: v = longint'($urandom_range(0, 200000)) - 100000;
          default: v = -(longint'(1) <<< 39) + longint'($urandom_range(0, 1000));
        endcase
        episode(int'($urandom_range(0, T - 1)), v, longint'($urandom_range(0, 15)),
                longint'($urandom_range(0, 65535)), int'($urandom_range(0, 5)));
      end
    end

    // Saturation of the detection counter in continuous mode.
    icontinuous = 1'b1;
    arm();
    for (int i = 0; i < 256; i++) begin
      trigger(1000 + longint'(i), longint'(i % 16), longint'(i * 3), acc);
      iresult_ack = 1'b1;
      tick();
      iresult_ack = 1'b0;
      repeat (G) tick();
    end
    chk("sat_det_en", longint'(o_det_en), 1);
    chk("sat_det_count", longint'(o_det_count), 255);
    icontinuous = 1'b0;
    erx_en = 1'b0;
    tick();
    erx_en = 1'b1;
    det_m = 0; rej_m = 0; last_v = 0; last_s = 0; last_t = 0;
    chk("dis_det_count", longint'(o_det_count), det_m);
    chk("dis_reject_count", longint'(o_reject_count), rej_m);
    chk("dis_value", longint'(o_result_value), last_v);
    chk("dis_seq", longint'(o_result_seq), last_s);
    chk("dis_time", longint'(o_result_time), last_t);
    chk("dis_busy", longint'(o_busy), 0);
    chk("dis_valid", longint'(o_result_valid), 0);

    repeat (3) tick();
    chk("sb_drained", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
